tbt_operand_loader: RTL and testbench
=====================================

Name: tbt_operand_loader

Overview:
- Upstream feeder for the 2x2 single-precision matrix multiplier.
- Accepts a serial stream of IEEE-754 binary32 words with a valid/ready handshake and packs 8 words into the multiplier's two 128-bit operand buses.
- Issues a one-cycle load to the multiplier, then blocks new input until the multiplier's result_ready rises or a timeout expires.

Parameters:
- TIMEOUT, 64: max cycles spent in WAIT before abort; legal range 2..65535.
- CNT_W, 16: width of the completed-set counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_data  in  32  binary32 element
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a word
- A  out  128  packed {a00,a01,a10,a11}
- B  out  128  packed {b00,b01,b10,b11}
- load  out  1  one-cycle issue strobe to the multiplier
- result_ready  in  1  multiplier done (level)
- busy  out  1  a set is issued and not yet completed
- special_flag  out  1  issued set contains Inf/NaN
- timeout_err  out  1  one-cycle pulse on WAIT timeout
- set_count  out  CNT_W  sets completed via result_ready

Behaviour:
- Reset values: in_ready=0, A=0, B=0, load=0, busy=0, special_flag=0, timeout_err=0, set_count=0, word index=0, state=FILL.
- Reset is synchronous and overrides everything, including mid-fill and mid-WAIT. It does not drive the multiplier's reset.
- Accept condition: a word is accepted on a rising edge with in_valid && in_ready. in_ready=1 only in FILL.
- Word order within a set:
  - idx 0..3 are A row-major: 0 to A[127:96], 1 to A[95:64], 2 to A[63:32], 3 to A[31:0].
  - idx 4..7 are B in the same slot order.
- Staging: words land in internal staging registers. A and B outputs change only at issue, so they stay stable while the multiplier works.
- Special detection: the staging flag sets when any accepted word has in_data[30:23]==8'hFF. It copies to special_flag at issue and clears for the next fill.
- State FILL:
  - Accept words and increment idx.
  - On accepting idx 7, go to ISSUE next cycle and reset idx to 0.
  - Stalled in_valid holds idx with no timeout.
- State ISSUE (exactly 1 cycle):
  - A/B registers take the staging contents; load=1; busy=1; timer cleared.
  - Go to WAIT.
  - Latency: the 8th accepted word at edge N gives load=1 and the new A/B visible during cycle N+1.
- State WAIT:
  - load=0, in_ready=0, busy=1.
  - Track result_ready with a registered copy (rr_q). The copy is updated every cycle in all states.
  - A rising edge (result_ready && !rr_q) sampled in WAIT moves to FILL with busy=0 and set_count+1 (wraps at 2^CNT_W).
  - A level that was already high when entering WAIT does not count as done. A rising edge must occur.
  - Timer increments each WAIT cycle. When the timer reaches TIMEOUT-1 without a rising edge: timeout_err pulses 1 cycle, go to FILL, busy=0, set_count unchanged, A/B retained.
  - A rising edge and a timeout in the same cycle count as success, with no error.
- Back-to-back sets: after returning to FILL, in_ready=1 the next cycle. There is no double-buffering, so the minimum set period is 8 + 1 + wait + 1 cycles.
- in_data is ignored whenever in_valid=0 or in_ready=0.

Test Plan:
- Reset then stream A={40BAE148,41028F5C,C040A3D7,C1200000}, B={41A73333,C14CCCCD,4115999A,40000000} with in_valid held high. Required: in_ready high for 8 cycles, load pulses once on the next cycle, A/B equal the packed values, busy=1, special_flag=0.
- From the state above, raise result_ready 5 cycles after load. Required: busy drops, set_count=1, and in_ready=1 on the following cycle. Then hold result_ready high through a second set's issue. Required: no completion until result_ready falls and rises again.
- Gapped stimulus, with in_valid toggling every other cycle. Required: same packing, load only after 8 accepted words, no extra words consumed.
- Word 5 = 7FC00000 (NaN). Required: special_flag=1 on the issued set, then 0 after a clean next set issues.
- Never assert result_ready with TIMEOUT=64. Required: timeout_err pulses exactly once, 64 cycles after entering WAIT; busy=0; set_count unchanged; A/B held.
- Assert reset after 3 words. Required: all outputs return to reset values. A subsequent full 8-word set packs from idx 0 with no leftover words.

Source files
------------

// File: rtl/tbt_operand_loader.sv
// Purpose: packs eight serial binary32 words into the 2x2 multiplier's A/B operand buses and issues a one-cycle load.
// Latency: the 8th accepted word at edge N shows load=1 and the new A/B during cycle N+1.
// Backpressure: in_ready is high only while filling; input stays blocked until result_ready rises or the wait times out.
module tbt_operand_loader #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     A,
    output logic [127:0]     B,
    output logic             load,
    input  logic             result_ready,
    output logic             busy,
    output logic             special_flag,
    output logic             timeout_err,
    output logic [CNT_W-1:0] set_count
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [7:0][31:0]   r_stage;
    logic               r_stage_spec;
    logic               r_rr_q;
    logic [15:0]        r_timer;
    logic               r_in_ready;
    logic [127:0]       r_a;
    logic [127:0]       r_b;
    logic               r_load;
    logic               r_busy;
    logic               r_special;
    logic               r_tout;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_word_spec;
    logic               w_rise;
    logic               w_timeout;
    logic [7:0][31:0]   w_stage_next;

    // in_ready is only ever set while filling, so it alone qualifies acceptance
    assign w_accept    = in_valid && r_in_ready;
    assign w_word_spec = (in_data[30:23] == 8'hFF);
    assign w_rise      = result_ready && !r_rr_q;
    assign w_timeout   = (r_timer == 16'(TIMEOUT - 1));

    // Staging view including the word accepted this cycle, so the 8th word can go straight to A/B
    always_comb begin
        w_stage_next = r_stage;
        if (w_accept) begin
            w_stage_next[r_idx] = in_data;
        end
    end

    // Registered copy of result_ready for rising-edge detection, kept live through reset and all states
    always_ff @(posedge clk) begin
        r_rr_q <= result_ready;
    end

    // Fill / issue / wait sequencing with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FILL;
            r_idx        <= 3'd0;
            r_stage      <= '0;
            r_stage_spec <= 1'b0;
            r_timer      <= 16'd0;
            r_in_ready   <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_special    <= 1'b0;
            r_tout       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_load <= 1'b0;
            r_tout <= 1'b0;
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_stage      <= w_stage_next;
                        r_stage_spec <= r_stage_spec | w_word_spec;
                        if (r_idx == 3'd7) begin
                            r_idx        <= 3'd0;
                            r_state      <= S_ISSUE;
                            r_in_ready   <= 1'b0;
                            r_a          <= {w_stage_next[0], w_stage_next[1], w_stage_next[2], w_stage_next[3]};
                            r_b          <= {w_stage_next[4], w_stage_next[5], w_stage_next[6], w_stage_next[7]};
                            r_load       <= 1'b1;
                            r_busy       <= 1'b1;
                            r_special    <= r_stage_spec | w_word_spec;
                            r_stage_spec <= 1'b0;
                            r_timer      <= 16'd0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_timer <= 16'd0;
                end
                S_WAIT: begin
                    // A rising edge wins over a coincident timeout
                    if (w_rise) begin
                        r_state    <= S_FILL;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_count    <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (w_timeout) begin
                        r_state    <= S_FILL;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_tout     <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign A            = r_a;
    assign B            = r_b;
    assign load         = r_load;
    assign busy         = r_busy;
    assign special_flag = r_special;
    assign timeout_err  = r_tout;
    assign set_count    = r_count;

endmodule

// File: tb/tb_tbt_operand_loader.sv
// Purpose: randomized and directed stimulus for tbt_operand_loader, checked against a queue-based reference model.
// Latency: the model predicts every output one clock ahead; outputs are sampled on the falling edge.
// Backpressure: the bench only advances its word stream when the model says a word was accepted.
module tb_tbt_operand_loader;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     A;
    logic [127:0]     B;
    logic             load;
    logic             result_ready;
    logic             busy;
    logic             special_flag;
    logic             timeout_err;
    logic [CNT_W-1:0] set_count;

    tbt_operand_loader #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .A            (A),
        .B            (B),
        .load         (load),
        .result_ready (result_ready),
        .busy         (busy),
        .special_flag (special_flag),
        .timeout_err  (timeout_err),
        .set_count    (set_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state: a word queue plus a coarse phase
    logic [31:0]      m_q[$];
    int               m_mode;
    int               m_wait;
    logic             m_rr;
    logic             m_in_ready;
    logic [127:0]     m_a;
    logic [127:0]     m_b;
    logic             m_load;
    logic             m_busy;
    logic             m_special;
    logic             m_tout;
    logic [CNT_W-1:0] m_count;

    logic [31:0] set1 [8];
    logic [31:0] set_nan [8];
    logic [31:0] set_rnd [8];

    localparam logic [127:0] PA = 128'h40BAE148_41028F5C_C040A3D7_C1200000;
    localparam logic [127:0] PB = 128'h41A73333_C14CCCCD_4115999A_40000000;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic rr, input logic rst);
        bit acc;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_wait = 0;
            m_in_ready = 0; m_a = '0; m_b = '0; m_load = 0;
            m_busy = 0; m_special = 0; m_tout = 0; m_count = '0;
        end else begin
            acc = v && m_in_ready;
            m_load = 0;
            m_tout = 0;
            case (m_mode)
                0: begin
                    if (acc) m_q.push_back(d);
                    if (m_q.size() == 8) begin
                        m_a = {m_q[0], m_q[1], m_q[2], m_q[3]};
                        m_b = {m_q[4], m_q[5], m_q[6], m_q[7]};
                        m_special = 0;
                        foreach (m_q[i]) if (m_q[i][30:23] == 8'hFF) m_special = 1;
                        m_q.delete();
                        m_load = 1; m_busy = 1; m_in_ready = 0; m_mode = 1;
                    end else begin
                        m_in_ready = 1;
                    end
                end
                1: begin
                    m_mode = 2; m_wait = 0;
                end
                default: begin
                    if (rr && !m_rr) begin
                        m_count = m_count + 1'b1;
                        m_busy = 0; m_in_ready = 1; m_mode = 0;
                    end else if (m_wait + 1 == TIMEOUT) begin
                        m_tout = 1; m_busy = 0; m_in_ready = 1; m_mode = 0;
                    end else begin
                        m_wait++;
                    end
                end
            endcase
        end
        m_rr = rr;
    endtask

    // compare all outputs at the falling edge, drive new inputs, advance the model, move to next falling edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic rr, input logic rst);
        check("in_ready", in_ready, m_in_ready);
        check("A", A, m_a);
        check("B", B, m_b);
        check("load", load, m_load);
        check("busy", busy, m_busy);
        check("special_flag", special_flag, m_special);
        check("timeout_err", timeout_err, m_tout);
        check("set_count", set_count, m_count);
        in_valid = v; in_data = d; result_ready = rr; reset = rst;
        model_edge(v, d, rr, rst);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cyc(1'b0, $urandom, rr, 1'b0);
    endtask

    task automatic feed(input logic [31:0] w [8], input int cnt, input bit gapped, input logic rr);
        int idx = 0;
        int guard = 0;
        bit v;
        bit acc;
        while (idx < cnt && guard < 200) begin
            v = gapped ? (guard % 2 == 0) : 1'b1;
            acc = v && m_in_ready;
            cyc(v, v ? w[idx] : $urandom, rr, 1'b0);
            if (acc) idx++;
            guard++;
        end
        if (idx != cnt) check("feed_budget", idx, cnt);
    endtask

    initial begin
        int n;
        logic [15:0] cnt_before;
        logic [31:0] d;
        set1    = '{32'h40BAE148, 32'h41028F5C, 32'hC040A3D7, 32'hC1200000,
                    32'h41A73333, 32'hC14CCCCD, 32'h4115999A, 32'h40000000};
        set_nan = set1;
        set_nan[5] = 32'h7FC00000;
        foreach (set_rnd[i]) set_rnd[i] = $urandom & 32'hBF7F_FFFF;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_edge(1'b0, 32'd0, 1'b0, 1'b1);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_count", set_count, 16'd0);

        // contiguous stream, completion 5 cycles after load
        feed(set1, 8, 1'b0, 1'b0);
        check("tp1_load", load, 1'b1);
        check("tp1_A", A, PA);
        check("tp1_B", B, PB);
        check("tp1_busy", busy, 1'b1);
        check("tp1_special", special_flag, 1'b0);
        idle(5, 1'b0);
        idle(1, 1'b1);
        check("tp2_busy", busy, 1'b0);
        check("tp2_count", set_count, 16'd1);
        check("tp2_in_ready", in_ready, 1'b1);

        // result_ready held high across issue must not complete
        feed(set_rnd, 8, 1'b0, 1'b1);
        idle(10, 1'b1);
        check("tp2_hold_busy", busy, 1'b1);
        check("tp2_hold_count", set_count, 16'd1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        check("tp2_rise_count", set_count, 16'd2);

        // gapped input
        feed(set1, 8, 1'b1, 1'b0);
        check("tp3_A", A, PA);
        check("tp3_B", B, PB);
        idle(2, 1'b0); idle(1, 1'b1); idle(1, 1'b0);

        // NaN detection, then cleared by a clean set
        feed(set_nan, 8, 1'b0, 1'b0);
        check("tp4_special", special_flag, 1'b1);
        idle(2, 1'b0); idle(1, 1'b1);
        feed(set1, 8, 1'b0, 1'b0);
        check("tp4_clean", special_flag, 1'b0);
        idle(2, 1'b0); idle(1, 1'b1); idle(1, 1'b0);

        // timeout with result_ready never asserted
        feed(set_rnd, 8, 1'b0, 1'b0);
        cnt_before = set_count;
        n = 0;
        while (timeout_err !== 1'b1 && n < 200) begin
            idle(1, 1'b0);
            n++;
        end
        check("tp5_latency", n, 1 + TIMEOUT);
        check("tp5_busy", busy, 1'b0);
        check("tp5_count", set_count, cnt_before);
        check("tp5_A", A, {set_rnd[0], set_rnd[1], set_rnd[2], set_rnd[3]});
        idle(1, 1'b0);
        check("tp5_single", timeout_err, 1'b0);

        // reset mid-fill
        feed(set_nan, 3, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check("tp6_A", A, 128'd0);
        check("tp6_in_ready", in_ready, 1'b0);
        check("tp6_count", set_count, 16'd0);
        feed(set1, 8, 1'b0, 1'b0);
        check("tp6_repack_A", A, PA);
        check("tp6_repack_B", B, PB);
        check("tp6_special", special_flag, 1'b0);
        idle(1, 1'b0); idle(1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
            if ($urandom_range(7) == 0) d[30:23] = 8'hFF;
            cyc($urandom_range(3) != 0, d, $urandom_range(5) == 0, $urandom_range(299) == 0);
        end
        idle(1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
